// File: rtl/spi_shift_engine.sv
// SPI master shift engine: pops TX words, serialises MSB-first on mosi, assembles miso into RX words.
// Supports all four CPOL/CPHA modes with a programmable sclk half-period of clkDiv+1 cycles.
module spi_shift_engine #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned DIVWIDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_cpol,
    input  logic                 i_cpha,
    input  logic [DIVWIDTH-1:0]  i_clk_div,
    input  logic                 i_tx_empty,
    input  logic [DATAWIDTH-1:0] i_tx_data,
    output logic                 o_tx_read_req,
    input  logic                 i_rx_full,
    output logic                 o_rx_write_en,
    output logic [DATAWIDTH-1:0] o_rx_data,
    output logic                 o_sclk,
    output logic                 o_mosi,
    input  logic                 i_miso,
    output logic                 o_ss_n,
    output logic                 o_busy,
    output logic                 o_rx_overflow,
    input  logic                 i_overflow_clear
);

    localparam int unsigned        EdgeW    = $clog2(2 * DATAWIDTH + 1);
    localparam logic [EdgeW-1:0]   LastEdge = EdgeW'(2 * DATAWIDTH);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StLoad,
        StShift,
        StDone,
        StStop
    } state_e;

    state_e               r_state;
    logic [DATAWIDTH-1:0] r_tx_shift;
    logic [DATAWIDTH-1:0] r_rx_shift;
    logic [DATAWIDTH-1:0] r_rx_data;
    logic [DIVWIDTH-1:0]  r_cnt;
    logic [DIVWIDTH-1:0]  r_div;
    logic [EdgeW-1:0]     r_edge;
    logic                 r_cpha;
    logic                 r_sclk;
    logic                 r_mosi;
    logic                 r_ss_n;
    logic                 r_tx_rd;
    logic                 r_ovf;

    logic                 w_tick;
    logic                 w_leading;
    logic                 w_last;
    logic                 w_sample;
    logic                 w_shift_out;
    logic                 w_more;
    logic [EdgeW-1:0]     w_edge_num;
    logic [DATAWIDTH-1:0] w_rx_next;

    // Edges are numbered from 1: odd edges lead, even edges trail.
    always_comb begin
        w_tick      = (r_cnt == r_div);
        w_edge_num  = r_edge + EdgeW'(1);
        w_leading   = w_edge_num[0];
        w_last      = (w_edge_num == LastEdge);
        w_sample    = w_tick && (w_leading ^ r_cpha);
        w_shift_out = w_tick && !(w_leading ^ r_cpha) && !w_last;
        w_rx_next   = w_sample ? {r_rx_shift[DATAWIDTH-2:0], i_miso} : r_rx_shift;
        w_more      = i_enable && !i_tx_empty;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_cnt      <= '0;
            r_div      <= '0;
            r_edge     <= '0;
            r_cpha     <= 1'b0;
            r_sclk     <= i_cpol;
            r_mosi     <= 1'b0;
            r_ss_n     <= 1'b1;
            r_tx_rd    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_tx_rd <= 1'b0;
            if (r_state == StDone && i_rx_full) begin
                r_ovf <= 1'b1;
            end else if (i_overflow_clear) begin
                r_ovf <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    r_sclk <= i_cpol;
                    r_ss_n <= 1'b1;
                    if (w_more) begin
                        r_state <= StSettle;
                    end
                end
                StSettle: begin
                    r_tx_rd <= 1'b1;
                    r_state <= StLoad;
                end
                StLoad: begin
                    // sclk itself carries the latched polarity for the rest of the word.
                    r_ss_n     <= 1'b0;
                    r_cpha     <= i_cpha;
                    r_div      <= i_clk_div;
                    r_sclk     <= i_cpol;
                    r_cnt      <= '0;
                    r_edge     <= '0;
                    r_rx_shift <= '0;
                    if (!i_cpha) begin
                        r_mosi     <= i_tx_data[DATAWIDTH-1];
                        r_tx_shift <= i_tx_data << 1;
                    end else begin
                        r_tx_shift <= i_tx_data;
                    end
                    r_state <= StShift;
                end
                StShift: begin
                    if (w_tick) begin
                        r_cnt  <= '0;
                        r_sclk <= ~r_sclk;
                        r_edge <= w_edge_num;
                    end else begin
                        r_cnt <= r_cnt + DIVWIDTH'(1);
                    end
                    r_rx_shift <= w_rx_next;
                    if (w_shift_out) begin
                        r_mosi     <= r_tx_shift[DATAWIDTH-1];
                        r_tx_shift <= r_tx_shift << 1;
                    end
                    if (w_tick && w_last) begin
                        r_rx_data <= w_rx_next;
                        r_state   <= StDone;
                    end
                end
                StDone: begin
                    r_cnt <= '0;
                    // Back-to-back words skip SETTLE and keep ssN low.
                    if (w_more) begin
                        r_tx_rd <= 1'b1;
                        r_state <= StLoad;
                    end else begin
                        r_state <= StStop;
                    end
                end
                StStop: begin
                    if (r_cnt == r_div) begin
                        r_ss_n  <= 1'b1;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + DIVWIDTH'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_tx_read_req = r_tx_rd;
    assign o_rx_write_en = (r_state == StDone) && !i_rx_full;
    assign o_rx_data     = r_rx_data;
    assign o_sclk        = r_sclk;
    assign o_mosi        = r_mosi;
    assign o_ss_n        = r_ss_n;
    assign o_busy        = (r_state != StIdle);
    assign o_rx_overflow = r_ovf;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Scoreboard bench for spi_shift_engine: TX/RX FIFO models, a cpha=1 slave model, and a negedge
// monitor that pops expected RX words whenever the engine pushes one.
module tb_spi_shift_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cpol;
    logic        cpha;
    logic [15:0] clk_div;
    logic        tx_empty = 1'b1;
    logic [7:0]  tx_data = 8'hEE;
    logic        tx_read_req;
    logic        rx_full;
    logic        rx_write_en;
    logic [7:0]  rx_data;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        ss_n;
    logic        busy;
    logic        rx_overflow;
    logic        overflow_clear;

    logic        loop_en;
    logic        slave_miso = 1'b0;
    logic [7:0]  slave_word;
    int          slave_idx = 0;

    assign miso = loop_en ? mosi : slave_miso;

    always #5 clk = ~clk;

    spi_shift_engine #(
        .DATAWIDTH(8),
        .DIVWIDTH (16)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_enable        (enable),
        .i_cpol          (cpol),
        .i_cpha          (cpha),
        .i_clk_div       (clk_div),
        .i_tx_empty      (tx_empty),
        .i_tx_data       (tx_data),
        .o_tx_read_req   (tx_read_req),
        .i_rx_full       (rx_full),
        .o_rx_write_en   (rx_write_en),
        .o_rx_data       (rx_data),
        .o_sclk          (sclk),
        .o_mosi          (mosi),
        .i_miso          (miso),
        .o_ss_n          (ss_n),
        .o_busy          (busy),
        .o_rx_overflow   (rx_overflow),
        .i_overflow_clear(overflow_clear)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // TX FIFO model: head word reaches tx_data two cycles after empty falls.
    logic [7:0] tx_q[$];
    logic [7:0] head_lag1 = 8'hEE;
    logic [7:0] head_lag2 = 8'hEE;
    logic [7:0] tx_pop;

    always @(posedge clk) begin
        if (tx_read_req && tx_q.size() > 0) tx_pop = tx_q.pop_front();
        tx_empty <= (tx_q.size() == 0);
        if (tx_q.size() > 0) head_lag1 <= tx_q[0];
        head_lag2 <= head_lag1;
        tx_data   <= head_lag2;
    end

    // Monitor and scoreboard.
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic       prev_sclk = 1'b0;
    logic       prev_ss_n = 1'b1;
    int         rd_times[$];
    int         wr_times[$];
    int         tog_times[$];
    int         rise_times[$];
    logic       lead_bits[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (tx_read_req) begin
                rd_times.push_back(cyc);
                check("txrd_while_empty", {31'b0, tx_empty}, 32'd0);
            end
            if (rx_write_en) begin
                wr_times.push_back(cyc);
                check("rxwe_while_full", {31'b0, rx_full}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rx_unexpected: got %0h want no push", rx_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rx_data", {24'b0, rx_data}, {24'b0, mon_exp});
                end
            end
            if (ss_n) slave_idx = 0;
            if (sclk !== prev_sclk) begin
                tog_times.push_back(cyc);
                if (sclk !== cpol) begin
                    lead_bits.push_back(mosi);
                    if (!loop_en && !ss_n && slave_idx < 8) begin
                        slave_miso = slave_word[7 - slave_idx];
                        slave_idx++;
                    end
                end
            end
            if (ss_n && !prev_ss_n) rise_times.push_back(cyc);
        end
        prev_sclk = sclk;
        prev_ss_n = ss_n;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rd(input int budget);
        int base = rd_times.size();
        int n = 0;
        while (rd_times.size() == base && n < budget) begin
            tick();
            n++;
        end
        if (rd_times.size() == base) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_txrd: got timeout want pop within %0d", budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        tick();
        while ((busy || !ss_n) && n < budget) begin
            tick();
            n++;
        end
        if (busy || !ss_n) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle: got busy=%0b ssN=%0b want idle", busy, ss_n);
        end
    endtask

    int rb, wb, tb, sb, lb, t_push, dmin, dmax, dd;
    logic [7:0] bits;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; enable = 1'b0; cpol = 1'b0; cpha = 1'b0; clk_div = 16'd0;
        rx_full = 1'b0; overflow_clear = 1'b0; loop_en = 1'b1; slave_word = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_sclk", {31'b0, sclk}, 32'd0);
        check("rst_mosi", {31'b0, mosi}, 32'd0);
        check("rst_ssn", {31'b0, ss_n}, 32'd1);
        check("rst_txrd", {31'b0, tx_read_req}, 32'd0);
        check("rst_rxwe", {31'b0, rx_write_en}, 32'd0);
        check("rst_rxdata", {24'b0, rx_data}, 32'd0);
        check("rst_ovf", {31'b0, rx_overflow}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);

        // Loopback mode 0, clkDiv=0, first write into an empty FIFO with stale head 0xEE
        enable = 1'b1;
        repeat (2) tick();
        rb = rd_times.size(); wb = wr_times.size(); sb = rise_times.size(); lb = lead_bits.size();
        exp_q.push_back(8'hA5);
        tx_q.push_back(8'hA5);
        t_push = cyc;
        wait_rd(20);
        wait_idle(100);
        check("a5_txrd_count", rd_times.size() - rb, 1);
        check("a5_rxwe_count", wr_times.size() - wb, 1);
        check("a5_lead_count", lead_bits.size() - lb, 8);
        if (rd_times.size() > rb) check("a5_settle_latency", rd_times[rb] - t_push, 3);
        if (lead_bits.size() >= lb + 8) begin
            for (int i = 0; i < 8; i++) bits[7 - i] = lead_bits[lb + i];
            check("a5_mosi_seq", {24'b0, bits}, 32'hA5);
        end
        if (wr_times.size() > wb && rd_times.size() > rb)
            check("a5_shift_len", wr_times[wb] - rd_times[rb] - 1, 16);
        if (wr_times.size() > wb && rise_times.size() > sb)
            check("a5_ssn_rise", rise_times[sb] - wr_times[wb], 2);
        check("a5_sclk_idle", {31'b0, sclk}, 32'd0);

        // Mode 3, clkDiv=3, slave drives 0x3C
        cpol = 1'b1; cpha = 1'b1; clk_div = 16'd3; loop_en = 1'b0; slave_word = 8'h3C;
        repeat (3) tick();
        check("m3_sclk_idle", {31'b0, sclk}, 32'd1);
        rb = rd_times.size(); wb = wr_times.size(); tb = tog_times.size();
        exp_q.push_back(8'h3C);
        tx_q.push_back(8'h81);
        wait_rd(20);
        wait_idle(300);
        check("m3_txrd_count", rd_times.size() - rb, 1);
        check("m3_rxwe_count", wr_times.size() - wb, 1);
        check("m3_toggles", tog_times.size() - tb, 16);
        dmin = 1000; dmax = 0;
        for (int i = tb + 1; i < tog_times.size(); i++) begin
            dd = tog_times[i] - tog_times[i - 1];
            if (dd < dmin) dmin = dd;
            if (dd > dmax) dmax = dd;
        end
        check("m3_half_min", dmin, 4);
        check("m3_half_max", dmax, 4);
        if (wr_times.size() > wb && rd_times.size() > rb)
            check("m3_shift_len", wr_times[wb] - rd_times[rb] - 1, 64);
        check("m3_sclk_end", {31'b0, sclk}, 32'd1);

        // Back-to-back 0x12, 0x34 in mode 0, clkDiv=1
        enable = 1'b0; cpol = 1'b0; cpha = 1'b0; clk_div = 16'd1; loop_en = 1'b1;
        repeat (2) tick();
        tx_q.push_back(8'h12);
        tx_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        repeat (5) tick();
        rb = rd_times.size(); wb = wr_times.size(); sb = rise_times.size();
        enable = 1'b1;
        wait_rd(20);
        wait_idle(200);
        check("b2b_txrd_count", rd_times.size() - rb, 2);
        check("b2b_rxwe_count", wr_times.size() - wb, 2);
        check("b2b_ssn_rises", rise_times.size() - sb, 1);
        if (rd_times.size() > rb + 1) check("b2b_txrd_gap", rd_times[rb + 1] - rd_times[rb], 34);

        // Overflow: rxFull during DONE
        clk_div = 16'd0; rx_full = 1'b1;
        tick();
        wb = wr_times.size();
        tx_q.push_back(8'h5A);
        wait_rd(20);
        wait_idle(100);
        check("ovf_set", {31'b0, rx_overflow}, 32'd1);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("ovf_cleared", {31'b0, rx_overflow}, 32'd0);
        tx_q.push_back(8'h6B);
        wait_rd(20);
        repeat (17) tick();
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("ovf_set_wins", {31'b0, rx_overflow}, 32'd1);
        wait_idle(100);
        check("ovf_no_push", wr_times.size() - wb, 0);
        rx_full = 1'b0;
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;

        // Reset mid-SHIFT after edge 5, mode 2
        cpol = 1'b1; cpha = 1'b0; clk_div = 16'd1;
        repeat (3) tick();
        wb = wr_times.size(); tb = tog_times.size();
        tx_q.push_back(8'h77);
        wait_rd(20);
        for (int n = 0; n < 100 && (tog_times.size() - tb) < 5; n++) tick();
        check("mid_edges", tog_times.size() - tb, 5);
        reset = 1'b1;
        enable = 1'b0;
        tick();
        reset = 1'b0;
        check("mid_ssn", {31'b0, ss_n}, 32'd1);
        check("mid_sclk", {31'b0, sclk}, 32'd1);
        check("mid_busy", {31'b0, busy}, 32'd0);
        repeat (40) tick();
        check("mid_no_push", wr_times.size() - wb, 0);

        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
